audio_sample_reader: RTL

AUDIO_SAMPLE_READER -- requirements
Module: audio_sample_reader

---
 rtl/audio_pkg.sv | 13 +
 rtl/audio_sample_fifo.sv | 55 +++++
 rtl/audio_sample_reader.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared constants and playback FSM encoding for the audio sample reader.
package audio_pkg;

    localparam int DEFAULT_ADDR_W = 13;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Show-ahead synchronous FIFO sitting between the sample memory and the codec stream.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module audio_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_flush,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_data,
    input  logic                    i_pop,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (o_count == '0);
    assign o_full  = (o_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = r_mem[r_rd_ptr[PTR_W-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + CNT_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + CNT_W'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end

endmodule

// File: rtl/audio_sample_reader.sv
// Streams a block of sample words from on-chip memory into a valid/ready codec stream,
// optionally looping, with credit-based flow control so returning read data is never dropped.
module audio_sample_reader
    import audio_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_en,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic [DATA_W-1:0]   sample_data,
    output logic                sample_valid,
    input  logic                sample_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int LEN_W = ADDR_W + 1;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [LEN_W-1:0]  r_length;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_loop;
    logic              r_inflight;
    logic              w_issue;
    logic              w_last;
    logic              w_credit;
    logic              w_flush;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [DATA_W-1:0] w_fifo_data;

    // A request is only issued when the FIFO is guaranteed room for its data one cycle later.
    assign w_credit = (w_count + CNT_W'(r_inflight)) < CNT_W'(FIFO_DEPTH);
    assign w_issue  = (r_state == RUN) && !stop && (r_remaining != '0) && w_credit;
    assign w_last   = (r_remaining == LEN_W'(1));

    assign busy           = (r_state != IDLE);
    assign mem_address    = r_rd_ptr;
    assign mem_chipselect = w_issue;
    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;
    assign mem_clken      = 1'b1;

    assign w_push       = r_inflight && !w_flush;
    assign w_pop        = sample_valid && sample_ready;
    assign sample_valid = !w_empty;
    assign sample_data  = w_empty ? '0 : w_fifo_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        done         = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next_state = (length == '0) ? DRAIN : RUN;
            end
            RUN: begin
                if (stop) begin
                    w_next_state = IDLE;
                    w_flush      = 1'b1;
                end else if (w_issue && w_last && !r_loop) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (stop) begin
                    w_next_state = IDLE;
                    w_flush      = 1'b1;
                end else if (!r_inflight && w_empty) begin
                    w_next_state = IDLE;
                    done         = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // With single-cycle read latency the in-flight word always retires in the stop cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base      <= '0;
            r_length    <= '0;
            r_loop      <= 1'b0;
            r_rd_ptr    <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (r_state == IDLE && start) begin
                r_base      <= base_addr;
                r_length    <= length;
                r_loop      <= loop_en;
                r_rd_ptr    <= base_addr;
                r_remaining <= length;
            end else if (w_issue) begin
                if (w_last && r_loop) begin
                    r_rd_ptr    <= r_base;
                    r_remaining <= r_length;
                end else begin
                    r_rd_ptr    <= r_rd_ptr + ADDR_W'(1);
                    r_remaining <= r_remaining - LEN_W'(1);
                end
            end
        end
    end

    audio_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (mem_readdata),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule
